// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: state encoding, FIFO geometry,
// and the half-bit counter preload.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_e;

  localparam int          FIFO_DEPTH = 16;
  localparam int          FIFO_AW    = 4;
  localparam logic [15:0] BAUD_MIN   = 16'd4;

  // Preload that makes the counter expire at the centre of the start bit.
  function automatic logic [15:0] half_period_load(input logic [15:0] baud);
    return (baud >> 1) - 16'd1;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Register-side view of the UART receiver: FIFO read port and sticky flags.
interface uart_rx_fifo_if;

  logic       rx_pop;
  logic [7:0] rx_data;
  logic       rx_empty;
  logic       rx_full;
  logic       rx_overrun;
  logic       rx_frame_err;
  logic       err_clr;

  modport master (
    output rx_pop, err_clr,
    input  rx_data, rx_empty, rx_full, rx_overrun, rx_frame_err
  );

  modport slave (
    input  rx_pop, err_clr,
    output rx_data, rx_empty, rx_full, rx_overrun, rx_frame_err
  );

endinterface

// File: rtl/uart_fifo.sv
// 16-deep synchronous byte FIFO with show-ahead read data.
// Writes while full and reads while empty are ignored.
module uart_fifo
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wr_en_i,
  input  logic [7:0] wdata_i,
  input  logic       rd_en_i,
  output logic [7:0] rdata_o,
  output logic       empty_o,
  output logic       full_o
);

  localparam int CW = FIFO_AW + 1;

  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wptr_q, wptr_d;
  logic [FIFO_AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0]      cnt_q,  cnt_d;
  logic               wr, rd;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(FIFO_DEPTH));
  assign wr      = wr_en_i && !full_o;
  assign rd      = rd_en_i && !empty_o;
  // Head is forced to zero while empty so the port has a defined reset value.
  assign rdata_o = empty_o ? 8'h00 : mem_q[rptr_q];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (wr) wptr_d = wptr_q + 1'b1;
    if (rd) rptr_d = rptr_q + 1'b1;
    case ({wr, rd})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver: synchronises rx, samples each bit at its centre and
// queues good bytes in a 16-entry FIFO with sticky overrun/framing flags.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int P_SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [15:0]       baudrate,
  input  logic              rx,
  uart_rx_fifo_if.slave     bus
);

  logic [P_SYNC_STAGES-1:0] sync_q;
  logic                     rxs;

  uart_state_e state_q, state_d;
  logic [15:0] cnt_q,   cnt_d;
  logic [2:0]  bidx_q,  bidx_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        ovr_q,   ovr_d;
  logic        ferr_q,  ferr_d;

  logic        expired;
  logic [15:0] baud_eff;
  logic        push, ovr_set, ferr_set;
  logic        fifo_full, fifo_empty;
  logic [7:0]  fifo_rdata;

  assign rxs      = sync_q[P_SYNC_STAGES-1];
  assign expired  = (cnt_q == 16'd0);
  // Out-of-range settings are clamped so the counter preloads never underflow.
  assign baud_eff = (baudrate < BAUD_MIN) ? BAUD_MIN : baudrate;

  always_comb begin
    state_d  = state_q;
    cnt_d    = expired ? 16'd0 : cnt_q - 16'd1;
    bidx_d   = bidx_q;
    shreg_d  = shreg_q;
    push     = 1'b0;
    ovr_set  = 1'b0;
    ferr_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rxs) begin
          cnt_d   = half_period_load(baud_eff);
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (expired) begin
          if (!rxs) begin
            cnt_d   = baud_eff - 16'd1;
            bidx_d  = 3'd0;
            state_d = ST_DATA;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (expired) begin
          shreg_d[bidx_q] = rxs;
          cnt_d           = baud_eff - 16'd1;
          if (bidx_q == 3'd7) state_d = ST_STOP;
          else                bidx_d  = bidx_q + 3'd1;
        end
      end
      ST_STOP: begin
        if (expired) begin
          if (rxs) begin
            // Full is judged before any same-cycle pop.
            if (!fifo_full) push    = 1'b1;
            else            ovr_set = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ferr_set = 1'b1;
            state_d  = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        if (rxs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    ovr_d  = ovr_set  | (ovr_q  & ~bus.err_clr);
    ferr_d = ferr_set | (ferr_q & ~bus.err_clr);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '1;
      state_q <= ST_IDLE;
      cnt_q   <= 16'd0;
      bidx_q  <= 3'd0;
      shreg_q <= 8'h00;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[P_SYNC_STAGES-2:0], rx};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bidx_q  <= bidx_d;
      shreg_q <= shreg_d;
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
    end
  end

  uart_fifo u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en_i (push),
    .wdata_i (shreg_q),
    .rd_en_i (bus.rx_pop),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign bus.rx_data      = fifo_rdata;
  assign bus.rx_empty     = fifo_empty;
  assign bus.rx_full      = fifo_full;
  assign bus.rx_overrun   = ovr_q;
  assign bus.rx_frame_err = ferr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: serial frames are driven on rx and the
// register-side outputs are compared against hand-computed values.
module tb_uart_rx_fifo;

  logic        clk;
  logic        reset_n;
  logic [15:0] baudrate;
  logic        rx;
  int          checks;
  int          failures;
  int          lat;

  uart_rx_fifo_if bus ();

  uart_rx_fifo #(.P_SYNC_STAGES(2)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .baudrate (baudrate),
    .rx       (rx),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bit_drive(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input int per, input logic stop);
    bit_drive(1'b0, per);
    for (int i = 0; i < 8; i++) bit_drive(d[i], per);
    bit_drive(stop, per);
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    chk(tag, {24'h0, bus.rx_data}, {24'h0, exp});
    bus.rx_pop = 1'b1;
    @(negedge clk);
    bus.rx_pop = 1'b0;
  endtask

  task automatic clear_flags();
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    reset_n     = 1'b0;
    baudrate    = 16'd16;
    rx          = 1'b1;
    bus.rx_pop  = 1'b0;
    bus.err_clr = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_empty",    32'(bus.rx_empty),     32'd1);
    chk("rst_full",     32'(bus.rx_full),      32'd0);
    chk("rst_overrun",  32'(bus.rx_overrun),   32'd0);
    chk("rst_frameerr", 32'(bus.rx_frame_err), 32'd0);
    chk("rst_data",     32'(bus.rx_data),      32'h00);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // Single byte; rx_empty expected to fall ~155 negedges after the start edge
    // (2 sync flops + 152 clk to the push + 1 clk to the flag).
    lat = 0;
    fork
      send_byte(8'h55, 16, 1'b1);
      begin
        while (bus.rx_empty && lat < 400) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    chk("single_latency", 32'(lat >= 152 && lat <= 158), 32'd1);
    chk("single_nonempty", 32'(bus.rx_empty), 32'd0);
    pop_chk("single_data", 8'h55);
    chk("single_empty_after_pop", 32'(bus.rx_empty), 32'd1);
    chk("single_overrun", 32'(bus.rx_overrun),   32'd0);
    chk("single_frameerr", 32'(bus.rx_frame_err), 32'd0);

    // Glitch shorter than half a bit is rejected.
    bit_drive(1'b0, 3);
    bit_drive(1'b1, 40);
    chk("glitch_empty",    32'(bus.rx_empty),     32'd1);
    chk("glitch_frameerr", 32'(bus.rx_frame_err), 32'd0);
    chk("glitch_overrun",  32'(bus.rx_overrun),   32'd0);
    send_byte(8'hA3, 16, 1'b1);
    bit_drive(1'b1, 4);
    chk("glitch_next_nonempty", 32'(bus.rx_empty), 32'd0);
    pop_chk("glitch_next_data", 8'hA3);
    chk("glitch_next_empty", 32'(bus.rx_empty), 32'd1);

    // Framing error followed by a long break.
    send_byte(8'hA5, 16, 1'b0);
    repeat (40 * 16) @(negedge clk);
    chk("ferr_set",   32'(bus.rx_frame_err), 32'd1);
    chk("ferr_empty", 32'(bus.rx_empty),     32'd1);
    bit_drive(1'b1, 32);
    send_byte(8'h3C, 16, 1'b1);
    bit_drive(1'b1, 4);
    chk("ferr_still_set", 32'(bus.rx_frame_err), 32'd1);
    chk("ferr_next_nonempty", 32'(bus.rx_empty), 32'd0);
    pop_chk("ferr_next_data", 8'h3C);
    clear_flags();
    chk("ferr_cleared", 32'(bus.rx_frame_err), 32'd0);

    // Overrun: 17 frames back to back, no pops.
    for (int i = 0; i < 17; i++) send_byte(8'(i), 16, 1'b1);
    bit_drive(1'b1, 4);
    chk("ovr_full", 32'(bus.rx_full),    32'd1);
    chk("ovr_set",  32'(bus.rx_overrun), 32'd1);
    for (int i = 0; i < 16; i++) pop_chk($sformatf("ovr_data%0d", i), 8'(i));
    chk("ovr_drained_empty", 32'(bus.rx_empty), 32'd1);
    chk("ovr_drained_full",  32'(bus.rx_full),  32'd0);
    clear_flags();
    chk("ovr_cleared", 32'(bus.rx_overrun), 32'd0);

    // Rate tolerance: receiver at 100 clk/bit, transmitter at 96 then 104.
    baudrate = 16'd100;
    bit_drive(1'b1, 20);
    send_byte(8'h00, 96, 1'b1);
    send_byte(8'hFF, 96, 1'b1);
    send_byte(8'h81, 96, 1'b1);
    send_byte(8'h00, 104, 1'b1);
    send_byte(8'hFF, 104, 1'b1);
    send_byte(8'h81, 104, 1'b1);
    bit_drive(1'b1, 20);
    pop_chk("tol96_0", 8'h00);
    pop_chk("tol96_1", 8'hFF);
    pop_chk("tol96_2", 8'h81);
    pop_chk("tol104_0", 8'h00);
    pop_chk("tol104_1", 8'hFF);
    pop_chk("tol104_2", 8'h81);
    chk("tol_empty",     32'(bus.rx_empty),     32'd1);
    chk("tol_frameerr",  32'(bus.rx_frame_err), 32'd0);

    // Pop in the same cycle as a push with 15 entries queued.
    baudrate = 16'd16;
    bit_drive(1'b1, 20);
    for (int i = 0; i < 15; i++) send_byte(8'h20 + 8'(i), 16, 1'b1);
    fork
      send_byte(8'h2F, 16, 1'b1);
      begin
        repeat (154) @(negedge clk);
        bus.rx_pop = 1'b1;
        @(negedge clk);
        bus.rx_pop = 1'b0;
      end
    join
    bit_drive(1'b1, 4);
    chk("pp_full",    32'(bus.rx_full),    32'd0);
    chk("pp_overrun", 32'(bus.rx_overrun), 32'd0);
    for (int i = 1; i < 16; i++) pop_chk($sformatf("pp_data%0d", i), 8'h20 + 8'(i));
    chk("pp_empty", 32'(bus.rx_empty), 32'd1);

    // Reset in the middle of a frame with two bytes queued.
    send_byte(8'h11, 16, 1'b1);
    send_byte(8'h22, 16, 1'b1);
    bit_drive(1'b1, 4);
    chk("mid_pre_nonempty", 32'(bus.rx_empty), 32'd0);
    bit_drive(1'b0, 16);
    for (int i = 0; i < 4; i++) bit_drive(1'((8'h5A >> i) & 8'h01), 16);
    reset_n = 1'b0;
    rx      = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_rst_empty",    32'(bus.rx_empty),     32'd1);
    chk("mid_rst_data",     32'(bus.rx_data),      32'h00);
    chk("mid_rst_overrun",  32'(bus.rx_overrun),   32'd0);
    chk("mid_rst_frameerr", 32'(bus.rx_frame_err), 32'd0);
    reset_n = 1'b1;
    bit_drive(1'b1, 10);
    send_byte(8'hC3, 16, 1'b1);
    bit_drive(1'b1, 4);
    chk("mid_next_nonempty", 32'(bus.rx_empty), 32'd0);
    pop_chk("mid_next_data", 8'hC3);
    chk("mid_next_empty",    32'(bus.rx_empty),     32'd1);
    chk("mid_next_frameerr", 32'(bus.rx_frame_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- UART receiver: deserialises 8N1 frames from the serial line `rx` into bytes.
- Stores received bytes in a 16-deep sync FIFO, read by the APB register block.
- Bit period is set by the same 16-bit `baudrate` register used by the transmit path, in clk cycles per bit.
- Detects framing errors (bad stop bit) and overrun (FIFO full); both are reported as sticky flags.

Parameters:
- P_SYNC_STAGES, 2, number of flops in the rx input synchroniser (legal values 2..3)

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- baudrate  input  16  clk cycles per bit; legal range 4..65535; must be static while a frame is in progress
- rx  input  1  asynchronous serial input; idle high
- rx_pop  input  1  consume FIFO head; ignored while rx_empty=1
- rx_data  output  8  FIFO head (show-ahead); valid while rx_empty=0
- rx_empty  output  1  FIFO empty
- rx_full  output  1  FIFO holds 16 bytes
- rx_overrun  output  1  sticky: a good frame was dropped because the FIFO was full
- rx_frame_err  output  1  sticky: a stop bit was sampled as 0
- err_clr  input  1  one-cycle pulse; clears both sticky flags

Behaviour:
- Reset values: rx_empty=1, rx_full=0, rx_overrun=0, rx_frame_err=0, rx_data=8'h00.
- Internal reset values: synchroniser=all 1s, state=IDLE, wait counter=0, bit index=0, shift register=0.
- Synchroniser: rx passes through P_SYNC_STAGES flops; its output is rxs. All decisions use rxs only.
- Wait counter: 16-bit down-counter; holds at 0. The phrase "expires" means counter==0 while in the state.
- State IDLE: if rxs==0, load counter with (baudrate>>1)-1 and go to START. Otherwise stay.
- State START (mid-start check): on expiry, sample rxs.
  - rxs==0: load baudrate-1, clear bit index, go to DATA.
  - rxs==1: glitch; go to IDLE. No flag, no push.
- State DATA: on expiry, shift rxs into bit[bit index] (LSB first) and reload baudrate-1.
  - Bit index 0..6: increment bit index.
  - Bit index 7: go to STOP.
- State STOP: on expiry, sample rxs.
  - rxs==1 and FIFO not full: push the byte; go to IDLE.
  - rxs==1 and FIFO full: discard the byte, set rx_overrun, go to IDLE.
  - rxs==0: discard the byte, set rx_frame_err, go to BREAK.
- State BREAK: wait for rxs==1, then go to IDLE. This prevents a held-low line from generating repeated frames.
- Sampling point: each bit is sampled at its centre, ±1 clk.
- Timing: the push occurs 9.5 bit periods (±2 clk) after rxs falls at the start bit. rx_empty deasserts on the clk after the push.
- Receiver timing tolerance: ±4% bit-rate mismatch versus the transmitter.
- FIFO read side:
  - rx_pop with rx_empty=0 removes the head; the next entry appears on rx_data the following cycle.
  - rx_pop with rx_empty=1 has no effect.
- Simultaneous push and pop:
  - FIFO not full: both take effect; occupancy is unchanged.
  - FIFO full: the push decision is made on the pre-pop full flag, so the byte is dropped and rx_overrun is set.
- Sticky flag priority: err_clr and a set event in the same cycle leave the flag set (set wins).
- Flag independence: flags never affect reception; the FIFO keeps accepting bytes while flags are set.
- Reset mid-frame: the partial frame is lost, the FIFO is emptied, and the state returns to IDLE. On reset release with rx held low, the block enters START after the synchroniser latency.
- baudrate changed mid-frame: behaviour undefined. Software changes it only while the line is idle.

Decomposition:
- Shared package uart_pkg: state encoding constants (IDLE, START, DATA, STOP, BREAK), FIFO depth 16, minimum baudrate 4.
- Sub-module: the existing uart_fifo (16-deep sync FIFO, show-ahead rdata) is instantiated for storage. Do not re-implement it.
- Synchroniser is inline, not a separate module.

Test Plan:
- Single byte: baudrate=16, drive frame 0x55 (start, bits LSB first, stop=1) → rx_empty falls about 152 clk after the start edge; rx_data=0x55; rx_pop → rx_empty=1; flags stay 0.
- Glitch: baudrate=16, drive rx low for 3 clk then high → no push, state returns to IDLE, flags 0. A following 0xA3 frame is received correctly.
- Framing error: frame 0xA5 with stop bit=0, then line held low 40 bit periods → rx_frame_err=1, FIFO empty, no further frames. Line high, then frame 0x3C → rx_data=0x3C. err_clr → rx_frame_err=0.
- Overrun: send 17 bytes 0x00..0x10 with no pops → rx_full=1, rx_overrun=1. Popping yields 0x00..0x0F in order, then rx_empty=1; 0x10 is lost.
- Rate tolerance and push/pop: baudrate=100, transmit at 96 and 104 clk/bit, bytes 0x00, 0xFF, 0x81 back-to-back → all received. Pop the same cycle as a push with 15 entries → occupancy stays 15, no overrun.
- Reset mid-frame: assert reset_n after bit 3 of 0x5A with 2 bytes in the FIFO → rx_empty=1, flags 0. After release, the next frame 0xC3 is received intact.
